cwt_delay_pair: RTL and testbench
=================================

Name: cwt_delay_pair

Overview:
- Upstream feeder for the wavelet difference stage.
- Buffers the incoming sample stream in a circular delay line.
- For each accepted sample x[n], presents the pair (x[n], x[n-lag]) on registered outputs with a valid/ready handshake.
- The pair drives the subtractor operands directly: out_cur goes to in1 and out_del goes to in2, producing x[n] - x[n-lag] for the current wavelet scale.

Parameters:
- BITS, 16, sample width in bits (two's complement, passed through unchanged).
- DEPTH_LOG2, 5, log2 of delay-line depth; DEPTH = 2^DEPTH_LOG2 entries; maximum lag is DEPTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  BITS  input sample x[n].
- lag  input  DEPTH_LOG2  new scale lag, sampled when lag_load=1.
- lag_load  input  1  one-cycle strobe: latch lag and re-prime.
- out_valid  output  1  out_cur and out_del hold a valid pair.
- out_ready  input  1  downstream consumes the pair this cycle.
- out_cur  output  BITS  x[n].
- out_del  output  BITS  x[n-lag].
- primed  output  1  fill >= cur_lag; the next accepted sample will produce a pair.

Behaviour:
- Internal state:
  - mem[DEPTH] x BITS, not reset.
  - wptr (DEPTH_LOG2 bits), the next write slot.
  - fill (DEPTH_LOG2 bits), samples accepted since the last flush, saturating at DEPTH-1.
  - cur_lag (DEPTH_LOG2 bits).
- Reset (rst=0, asynchronous): out_valid=0, out_cur=0, out_del=0, wptr=0, fill=0, cur_lag=0. primed=1, because fill >= 0.
- in_ready = !lag_load && (!out_valid || out_ready). This is combinational and allows one pair per cycle when out_ready is held high.
- Accept = in_valid && in_ready. On accept:
  - mem[wptr] <= in_data.
  - wptr <= wptr+1, wrapping mod DEPTH.
  - fill <= min(fill+1, DEPTH-1).
- Pair generation on accept when fill >= cur_lag (evaluated with pre-increment fill):
  - out_cur <= in_data.
  - out_del <= in_data if cur_lag==0, otherwise mem[(wptr - cur_lag) mod DEPTH], read before this cycle's write.
  - out_valid <= 1.
- Accept while fill < cur_lag (priming): the sample is written and fill increments. No pair is produced; out_valid <= 0 if out_ready, otherwise it holds.
- Latency: the pair appears on the outputs 1 cycle after the accepting edge.
- Handshake:
  - A pair is transferred when out_valid && out_ready.
  - With no new pair generated, out_valid falls the cycle after transfer.
  - While out_valid=1 and out_ready=0, out_cur, out_del and out_valid hold stable, and in_ready=0.
- lag_load=1:
  - cur_lag <= lag, fill <= 0, out_valid <= 0 (any pending pair is discarded).
  - wptr and mem are unchanged.
  - in_ready is forced to 0 that cycle, so lag_load has priority over a simultaneous sample.
  - After the load, exactly cur_lag samples are consumed silently before the first pair.
- Wrap-around:
  - Pointer arithmetic is unsigned mod DEPTH.
  - lag = DEPTH-1 reads slot wptr+1, the oldest stored sample.
  - fill saturation keeps the block primed indefinitely.
- Arithmetic: no sign handling or width change; samples pass through bit-exact.
- Reset mid-stream clears the pending pair and pointers immediately (asynchronous). Stale mem contents are unreachable until re-primed, because fill=0.

Test Plan:
- Reset then lag_load with lag=3; feed samples 10,20,30,40,50 with out_ready=1 -> first three accepted with no output; then pairs (40,10) and (50,20), each 1 cycle after acceptance.
- lag=0; feed 0x7FFF then 0x8000 -> pairs (0x7FFF,0x7FFF) and (0x8000,0x8000); primed=1 throughout.
- lag=2 primed; hold out_ready=0 with in_valid=1 -> in_ready=0; outputs stable for 5 cycles; release -> next sample accepted the same cycle out_ready=1, giving back-to-back pairs.
- DEPTH_LOG2=5, lag=31; stream ramp 0..40 -> sample n=31 produces (31,0); sample n=40 produces (40,9); pointer wraps with no glitch.
- lag_load with lag=1 asserted while out_valid=1 and in_valid=1 -> pending pair dropped; sample not accepted that cycle; next sample primes; the following sample produces a pair.
- rst pulsed low mid-stream with out_valid=1 -> out_valid, out_cur and out_del go to 0 asynchronously before the next edge; cur_lag=0, so the next sample yields (x,x).

Source files
------------

// File: rtl/cwt_delay_pair.sv
// cwt_delay_pair
//   Feeds the wavelet difference stage. Incoming samples are stored in a
//   circular delay line; each accepted sample x[n] is presented together with
//   x[n-lag] on registered outputs (out_cur -> subtractor in1,
//   out_del -> subtractor in2).
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  in_data holds a sample
//   in_ready  block can accept a sample this cycle (combinational)
//   in_data   sample x[n], two's complement, passed through bit-exact
//   lag       new scale lag, latched when lag_load=1
//   lag_load  one-cycle strobe: latch lag, flush fill, drop pending pair
//   out_valid out_cur/out_del hold a valid pair
//   out_ready downstream consumes the pair this cycle
//   out_cur   x[n]
//   out_del   x[n-lag]
//   primed    fill >= cur_lag; the next accepted sample produces a pair
module cwt_delay_pair #(
  parameter int BITS       = 16,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  input  logic [DEPTH_LOG2-1:0] lag,
  input  logic                  lag_load,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_cur,
  output logic [BITS-1:0]       out_del,
  output logic                  primed
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [BITS-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] fill;
  logic [DEPTH_LOG2-1:0] cur_lag;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  accept;

  always_comb begin
    in_ready = !lag_load && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    primed   = (fill >= cur_lag);
    // Modulo-DEPTH subtraction falls out of the pointer width.
    rd_idx   = wptr - cur_lag;
  end

  // Delay line storage carries no reset; stale entries are never read
  // because a pair is only formed once fill covers the lag.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      fill      <= '0;
      cur_lag   <= '0;
      out_valid <= 1'b0;
      out_cur   <= '0;
      out_del   <= '0;
    end else if (lag_load) begin
      cur_lag   <= lag;
      fill      <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      wptr <= wptr + PTR_ONE;
      if (fill != '1) fill <= fill + PTR_ONE;
      if (primed) begin
        out_cur   <= in_data;
        // mem read sees the pre-write contents; lag 0 bypasses the array.
        out_del   <= (cur_lag == '0) ? in_data : mem[rd_idx];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cwt_delay_pair.sv
module tb_cwt_delay_pair;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  lag;
  logic        lag_load;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cur;
  logic [15:0] out_del;
  logic        primed;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: samples accepted since the last flush (newest at back).
  logic [15:0] hist [$];
  int unsigned m_lag;
  logic        m_valid;
  logic [15:0] m_cur;
  logic [15:0] m_del;
  logic        exp_in_ready;
  logic        obs_in_ready;

  cwt_delay_pair #(.BITS(16), .DEPTH_LOG2(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .lag(lag), .lag_load(lag_load),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cur(out_cur), .out_del(out_del), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    hist.delete();
    m_lag   = 0;
    m_valid = 1'b0;
    m_cur   = '0;
    m_del   = '0;
  endtask

  function automatic logic [34:0] exp_vec();
    return {exp_in_ready, m_valid, logic'(hist.size() >= m_lag), m_cur, m_del};
  endfunction

  function automatic logic [34:0] obs_vec();
    return {obs_in_ready, out_valid, primed, out_cur, out_del};
  endfunction

  // Drive one cycle of inputs, sample in_ready before the edge, advance model.
  task automatic step(input logic v, input logic [15:0] d, input logic rdy,
                      input logic ld, input logic [4:0] lg);
    logic acc;
    in_valid = v; in_data = d; out_ready = rdy; lag_load = ld; lag = lg;
    #1;
    obs_in_ready = in_ready;
    exp_in_ready = !ld && (!m_valid || rdy);
    acc = v && exp_in_ready;
    if (ld) begin
      m_lag = int'(lg);
      hist.delete();
      m_valid = 1'b0;
    end else if (acc) begin
      if (hist.size() >= m_lag) begin
        m_cur   = d;
        m_del   = (m_lag == 0) ? d : hist[hist.size() - m_lag];
        m_valid = 1'b1;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      hist.push_back(d);
      if (hist.size() > 32) void'(hist.pop_front());
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 0; in_data = '0; out_ready = 0; lag_load = 0; lag = '0;
    model_reset();
    #1;
    obs_in_ready = in_ready;
    vectors++;
    if (obs_vec() !== {1'b1, 1'b0, 1'b1, 16'h0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset: got %h want %h", obs_vec(), {1'b1, 1'b0, 1'b1, 16'h0, 16'h0});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lag3();
    logic [15:0] s [5] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50};
    step(0, '0, 1, 1, 5'd3);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL lag3_load: got %h want %h", obs_vec(), exp_vec());
    end
    for (int unsigned i = 0; i < 5; i++) begin
      step(1, s[i], 1, 0, '0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL lag3 sample %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        vectors++;
        if ({out_valid, out_cur, out_del} !== {1'b1, 16'd40, 16'd10}) begin
          miscompares++; $display("FAIL lag3 pair40: got %h want %h", {out_valid, out_cur, out_del}, {1'b1, 16'd40, 16'd10});
        end
      end
      if (i == 4) begin
        vectors++;
        if ({out_valid, out_cur, out_del} !== {1'b1, 16'd50, 16'd20}) begin
          miscompares++; $display("FAIL lag3 pair50: got %h want %h", {out_valid, out_cur, out_del}, {1'b1, 16'd50, 16'd20});
        end
      end
    end
  endtask

  task automatic test_lag0_extremes();
    logic [15:0] s [2] = '{16'h7FFF, 16'h8000};
    step(0, '0, 1, 1, 5'd0);
    for (int unsigned i = 0; i < 2; i++) begin
      step(1, s[i], 1, 0, '0);
      vectors++;
      if ({out_valid, primed, out_cur, out_del} !== {1'b1, 1'b1, s[i], s[i]}) begin
        miscompares++; $display("FAIL lag0 %0d: got %h want %h", i, {out_valid, primed, out_cur, out_del}, {1'b1, 1'b1, s[i], s[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    step(0, '0, 1, 1, 5'd2);
    for (int unsigned i = 0; i < 3; i++) step(1, 16'(100 + i), 1, 0, '0);
    // Stall: pair from sample 102 must hold, nothing accepted.
    for (int unsigned i = 0; i < 5; i++) begin
      step(1, 16'(200 + i), 0, 0, '0);
      vectors++;
      if (obs_vec() !== exp_vec() || in_ready !== 1'b0 || out_cur !== 16'd102 || out_del !== 16'd100) begin
        miscompares++; $display("FAIL stall %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      step(1, 16'(300 + i), 1, 0, '0);
      vectors++;
      if (obs_vec() !== exp_vec() || obs_in_ready !== 1'b1 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL release %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    step(0, '0, 1, 1, 5'd31);
    for (int unsigned n = 0; n <= 40; n++) begin
      step(1, 16'(n), 1, 0, '0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL wrap n=%0d: got %h want %h", n, obs_vec(), exp_vec());
      end
      if (n == 31 || n == 40) begin
        vectors++;
        if ({out_valid, out_cur, out_del} !== {1'b1, 16'(n), 16'(n - 31)}) begin
          miscompares++; $display("FAIL wrap pair n=%0d: got %h want %h", n, {out_valid, out_cur, out_del}, {1'b1, 16'(n), 16'(n - 31)});
        end
      end
    end
  endtask

  task automatic test_load_priority();
    step(0, '0, 1, 1, 5'd1);
    step(1, 16'hA0, 1, 0, '0);
    step(1, 16'hB0, 1, 0, '0);
    // Load collides with a pending pair and an offered sample.
    step(1, 16'hC0, 1, 1, 5'd1);
    vectors++;
    if (obs_in_ready !== 1'b0 || out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL load_priority: got %h want %h", obs_vec(), exp_vec());
    end
    step(1, 16'hD0, 1, 0, '0);
    vectors++;
    if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL load_prime: got %h want %h", obs_vec(), exp_vec());
    end
    step(1, 16'hE0, 1, 0, '0);
    vectors++;
    if ({out_valid, out_cur, out_del} !== {1'b1, 16'hE0, 16'hD0}) begin
      miscompares++; $display("FAIL load_pair: got %h want %h", {out_valid, out_cur, out_del}, {1'b1, 16'hE0, 16'hD0});
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 3) != 0), 16'($urandom),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0),
           5'($urandom_range(0, 31)));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, '0, 1, 1, 5'd2);
    for (int unsigned i = 0; i < 3; i++) step(1, 16'(16'h1230 + i), 1, 0, '0);
    step(0, '0, 0, 0, '0);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_cur, out_del, primed} !== {1'b0, 16'h0, 16'h0, 1'b1}) begin
      miscompares++; $display("FAIL async_reset: got %h want %h", {out_valid, out_cur, out_del, primed}, {1'b0, 16'h0, 16'h0, 1'b1});
    end
    in_valid = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 16'h5A5A, 1, 0, '0);
    vectors++;
    if ({out_valid, out_cur, out_del} !== {1'b1, 16'h5A5A, 16'h5A5A}) begin
      miscompares++; $display("FAIL post_reset_pair: got %h want %h", {out_valid, out_cur, out_del}, {1'b1, 16'h5A5A, 16'h5A5A});
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_lag3();
    test_lag0_extremes();
    test_backpressure();
    test_wrap();
    test_load_priority();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
